// File: rtl/d_ff.sv
// d_ff: rising-edge D flip-flop / WIDTH-bit register with synchronous active-high reset to RESET_VAL.
// Optional load enable: define D_FF_LOAD_EN to add the en port; otherwise q captures d on every edge.
module d_ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
`ifdef D_FF_LOAD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef D_FF_LOAD_EN
    // Reset outranks en; a deasserted en holds the stored word.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed vectors for d_ff instances (single bit, reset priority, 64-bit, 135-bit
// inverted-clock pipeline, 3-stage chain, optional D_FF_LOAD_EN) checked through an expected queue.
module tb_d_ff;

    localparam int TAG_Q1    = 0;
    localparam int TAG_Q8    = 1;
    localparam int TAG_Q64   = 2;
    localparam int TAG_PIPE  = 3;
    localparam int TAG_CHAIN = 4;
    localparam int TAG_Q16   = 5;

    // Clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic clkN;
    assign clkN = ~clk;

    logic        rst1;
    logic        d1;
    logic        q1;
    logic        rst8;
    logic [7:0]  d8;
    logic [7:0]  q8;
    logic        rst64;
    logic [63:0] d64;
    logic [63:0] q64;
    logic [134:0] pipeIn;
    logic [134:0] pipeOut;
    logic        rstC;
    logic        dC;
    logic        qC1;
    logic        qC2;
    logic        qC3;
`ifdef D_FF_LOAD_EN
    logic        rst16;
    logic        en16;
    logic [15:0] d16;
    logic [15:0] q16;
`endif

    d_ff #(.WIDTH(1)) u1 (
        .clk(clk), .reset(rst1),
`ifdef D_FF_LOAD_EN
        .en(1'b1),
`endif
        .d(d1), .q(q1)
    );

    d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (
        .clk(clk), .reset(rst8),
`ifdef D_FF_LOAD_EN
        .en(1'b1),
`endif
        .d(d8), .q(q8)
    );

    d_ff #(.WIDTH(64)) u64 (
        .clk(clk), .reset(rst64),
`ifdef D_FF_LOAD_EN
        .en(1'b1),
`endif
        .d(d64), .q(q64)
    );

    // MEM/WB-style register: one single-bit instance per bit on the inverted clock.
    for (genvar i = 0; i < 135; i++) begin : gPipe
        d_ff #(.WIDTH(1)) uBit (
            .clk(clkN), .reset(1'b0),
`ifdef D_FF_LOAD_EN
            .en(1'b1),
`endif
            .d(pipeIn[i]), .q(pipeOut[i])
        );
    end

    d_ff #(.WIDTH(1)) uC1 (
        .clk(clk), .reset(rstC),
`ifdef D_FF_LOAD_EN
        .en(1'b1),
`endif
        .d(dC), .q(qC1)
    );
    d_ff #(.WIDTH(1)) uC2 (
        .clk(clk), .reset(rstC),
`ifdef D_FF_LOAD_EN
        .en(1'b1),
`endif
        .d(qC1), .q(qC2)
    );
    d_ff #(.WIDTH(1)) uC3 (
        .clk(clk), .reset(rstC),
`ifdef D_FF_LOAD_EN
        .en(1'b1),
`endif
        .d(qC2), .q(qC3)
    );

`ifdef D_FF_LOAD_EN
    d_ff #(.WIDTH(16), .RESET_VAL(16'h5A5A)) u16 (
        .clk(clk), .reset(rst16), .en(en16), .d(d16), .q(q16)
    );
`endif

    // Scoreboard
    logic [255:0] exp_q[$];
    int           tagQ[$];
    int           nVec = 0;
    int           nErr = 0;

    function automatic logic [255:0] actualOf(input int tag);
        logic [255:0] a;
        a = '0;
        case (tag)
            TAG_Q1:    a = 256'(q1);
            TAG_Q8:    a = 256'(q8);
            TAG_Q64:   a = 256'(q64);
            TAG_PIPE:  a = 256'(pipeOut);
            TAG_CHAIN: a = 256'({qC3, qC2, qC1});
`ifdef D_FF_LOAD_EN
            TAG_Q16:   a = 256'(q16);
`endif
            default:   a = 'x;
        endcase
        return a;
    endfunction

    function automatic string tagName(input int tag);
        case (tag)
            TAG_Q1:    return "q_w1";
            TAG_Q8:    return "q_w8";
            TAG_Q64:   return "q_w64";
            TAG_PIPE:  return "pipe_memwb";
            TAG_CHAIN: return "chain_q3q2q1";
            TAG_Q16:   return "q_w16_en";
            default:   return "unknown";
        endcase
    endfunction

    // Monitor: every expectation pushed before a rising edge is checked just after it.
    initial begin
        logic [255:0] expV;
        logic [255:0] actV;
        int           tag;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                tag  = tagQ.pop_front();
                expV = exp_q.pop_front();
                actV = actualOf(tag);
                nVec++;
                if (actV !== expV) begin
                    nErr++;
                    $display("FAIL %s: got %0h expected %0h at %0t", tagName(tag), actV, expV, $time);
                end
            end
        end
    end

    // Driver tasks
    task automatic push(input int tag, input logic [255:0] v);
        tagQ.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic testReset();
        rst1 = 1'b1; d1 = 1'b1;
        rst8 = 1'b1; d8 = 8'h3C;
        rst64 = 1'b1; d64 = 64'd7;
        rstC = 1'b1; dC = 1'b1;
        pipeIn = '0;
        push(TAG_Q1, 256'(1'b0));
        push(TAG_Q8, 256'(8'hA5));
        push(TAG_Q64, 256'(64'd0));
        push(TAG_CHAIN, 256'(3'b000));
`ifdef D_FF_LOAD_EN
        rst16 = 1'b1; en16 = 1'b0; d16 = 16'hFFFF;
        push(TAG_Q16, 256'(16'h5A5A));
`endif
        nextCycle();
    endtask

    task automatic testSingle();
        rst1 = 1'b0;
        d1 = 1'b1; push(TAG_Q1, 256'(1'b1)); nextCycle();
        d1 = 1'b0; push(TAG_Q1, 256'(1'b0)); nextCycle();
        // Glitch d around the falling edge; the next rising edge must still see 0.
        push(TAG_Q1, 256'(1'b0));
        #4 d1 = 1'b1;
        #3 d1 = 1'b0;
        nextCycle();
        d1 = 1'b1; push(TAG_Q1, 256'(1'b1)); nextCycle();
    endtask

    task automatic testReset8();
        rst8 = 1'b1; d8 = 8'h3C; push(TAG_Q8, 256'(8'hA5)); nextCycle();
        rst8 = 1'b0;             push(TAG_Q8, 256'(8'h3C)); nextCycle();
    endtask

    task automatic testMid64();
        rst64 = 1'b0;
        d64 = 64'd42069; push(TAG_Q64, 256'(64'd42069)); nextCycle();
        d64 = 64'd69420; push(TAG_Q64, 256'(64'd69420)); nextCycle();
        rst64 = 1'b1;    push(TAG_Q64, 256'(64'd0));     nextCycle();
        d64 = 64'd12345; push(TAG_Q64, 256'(64'd0));     nextCycle();
        rst64 = 1'b0;    push(TAG_Q64, 256'(64'd12345)); nextCycle();
    endtask

    task automatic testPipe();
        logic [134:0] want;
        want = {1'b1, 1'b1, 5'd15, 64'd69420, 64'd42069};
        pipeIn = {1'b1, 1'b1, 5'd15, 64'd69420, 64'd42069};
        for (int i = 0; i < 3; i++) begin
            push(TAG_PIPE, 256'(want));
            nextCycle();
        end
    endtask

    task automatic testChain();
        rstC = 1'b1; dC = 1'b0; push(TAG_CHAIN, 256'(3'b000)); nextCycle();
        rstC = 1'b0; dC = 1'b1; push(TAG_CHAIN, 256'(3'b001)); nextCycle();
        dC = 1'b0;              push(TAG_CHAIN, 256'(3'b010)); nextCycle();
                                push(TAG_CHAIN, 256'(3'b100)); nextCycle();
                                push(TAG_CHAIN, 256'(3'b000)); nextCycle();
    endtask

`ifdef D_FF_LOAD_EN
    task automatic testEn16();
        rst16 = 1'b0; en16 = 1'b1; d16 = 16'h1234; push(TAG_Q16, 256'(16'h1234)); nextCycle();
        en16 = 1'b0; d16 = 16'hBEEF;              push(TAG_Q16, 256'(16'h1234)); nextCycle();
        en16 = 1'b1;                               push(TAG_Q16, 256'(16'hBEEF)); nextCycle();
        rst16 = 1'b1; en16 = 1'b0;                 push(TAG_Q16, 256'(16'h5A5A)); nextCycle();
    endtask
`endif

    initial begin
        testReset();
        testSingle();
        testReset8();
        testMid64();
        testPipe();
        testChain();
`ifdef D_FF_LOAD_EN
        testEn16();
`endif
        repeat (2) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            nErr++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
